lcv_iter_div: RTL

Multi-cycle iterative restoring divider: the inverse counterpart to the DSP multiply-accumulate units. Accepts a dividend/divisor pair over a valid/ready handshake, runs one quotient bit per clock through a shared subtractor, and returns quotient and remainder over a second valid/ready handshake. Sits beside the mul-acc and ALU units in the execute stage, servicing DIV/REM operations that do not fit the single-cycle datapath.

---
 rtl/lcv_div_pkg.sv | 10 +
 rtl/lcv_div_step.sv | 19 +
 rtl/lcv_iter_div.sv | 97 +++++++++
 3 files changed

// File: rtl/lcv_div_pkg.sv
// lcv_div_pkg: shared types and sizing helpers for the iterative divider
package lcv_div_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  function automatic logic [63:0] dz_quot(int w);
    return {64{1'b1}} >> (64 - w);
  endfunction
  function automatic int cnt_width(int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/lcv_div_step.sv
// lcv_div_step: one combinational restoring-division step
// rem_in/rem_out: partial remainder (WIDTH+1), bit_in: next dividend bit,
// divisor: divisor magnitude, q: quotient bit produced by this step
module lcv_div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q
);
  logic [WIDTH:0] sh, diff;
  logic unused_msb;
  // partial remainder is always below the divisor, so its top bit is never set
  assign unused_msb = rem_in[WIDTH];
  assign sh = {rem_in[WIDTH-1:0], bit_in};
  assign diff = sh - {1'b0, divisor};
  assign q = ~diff[WIDTH];
  assign rem_out = q ? diff : sh;
endmodule

// File: rtl/lcv_iter_div.sv
// lcv_iter_div: multi-cycle restoring divider, one quotient bit per clock
// clk, rst (async assert, active-low); inp_valid/inp_ready with
// inp_dividend, inp_divisor, inp_signed; outp_valid/outp_ready with
// outp_quot, outp_rem. Define LCV_ITER_DIV_SIGNED_EN to honour inp_signed.
module lcv_iter_div import lcv_div_pkg::*; #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inp_valid,
  output logic             inp_ready,
  input  logic [WIDTH-1:0] inp_dividend,
  input  logic [WIDTH-1:0] inp_divisor,
  input  logic             inp_signed,
  output logic             outp_valid,
  input  logic             outp_ready,
  output logic [WIDTH-1:0] outp_quot,
  output logic [WIDTH-1:0] outp_rem
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] DZQ = WIDTH'(dz_quot(WIDTH));
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] prem, prem_nx;
  logic [WIDTH-1:0] acc, dvs, mag_a, mag_b, quot_nx, rem_nx;
  logic qbit, dz;
`ifdef LCV_ITER_DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MNEG = {1'b1, {(WIDTH-1){1'b0}}};
  logic sa, sb, qneg, rneg, ovf;
  assign sa = inp_signed & inp_dividend[WIDTH-1];
  assign sb = inp_signed & inp_divisor[WIDTH-1];
  assign mag_a = sa ? -inp_dividend : inp_dividend;
  assign mag_b = sb ? -inp_divisor : inp_divisor;
  // the divide-by-zero remainder is |dividend| re-signed, i.e. the dividend itself
  assign quot_nx = ovf ? MNEG : dz ? DZQ : qneg ? -acc : acc;
  assign rem_nx = ovf ? '0 : rneg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
`else
  logic unused_signed;
  assign unused_signed = inp_signed;
  assign mag_a = inp_dividend;
  assign mag_b = inp_divisor;
  assign quot_nx = dz ? DZQ : acc;
  assign rem_nx = prem[WIDTH-1:0];
`endif
  lcv_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in(prem), .bit_in(acc[WIDTH-1]), .divisor(dvs), .rem_out(prem_nx), .q(qbit)
  );
  assign inp_ready = (state == IDLE) && rst;
  assign outp_valid = (state == DONE);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (inp_valid) state_nx = CALC;
      CALC: if (cnt == '0) state_nx = FIX;
      FIX:  state_nx = DONE;
      DONE: if (outp_ready) state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      prem <= '0;
      acc <= '0;
      dvs <= '0;
      dz <= 1'b0;
      outp_quot <= '0;
      outp_rem <= '0;
`ifdef LCV_ITER_DIV_SIGNED_EN
      qneg <= 1'b0;
      rneg <= 1'b0;
      ovf <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == IDLE && inp_valid) begin
        acc <= mag_a;
        dvs <= mag_b;
        prem <= '0;
        cnt <= CW'(WIDTH - 1);
        dz <= (inp_divisor == '0);
`ifdef LCV_ITER_DIV_SIGNED_EN
        qneg <= sa ^ sb;
        rneg <= sa;
        ovf <= sa && inp_dividend == MNEG && &inp_divisor;
`endif
      end
      // acc shifts dividend bits out the top and quotient bits in the bottom
      if (state == CALC) begin
        prem <= prem_nx;
        acc <= {acc[WIDTH-2:0], qbit};
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) begin
        outp_quot <= quot_nx;
        outp_rem <= rem_nx;
      end
    end
endmodule
